// File: rtl/sobel_pkg.sv
// Shared constants and state encoding for the 5x5 Sobel window controller.
package sobel_pkg;

    localparam int KERNEL    = 5;
    localparam int PIX_W     = 8;
    localparam int WIN_W     = KERNEL * KERNEL * PIX_W;
    localparam int SOBEL_LAT = 3;
    localparam int TAG_DEPTH = SOBEL_LAT + 1;
    localparam int LB_LINES  = KERNEL - 1;
    localparam int LB_W      = LB_LINES * PIX_W;

    localparam logic [1:0] DRAIN_LAST = 2'(TAG_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Bit offset of window pixel (row, col); z0 sits in the top byte.
    function automatic int win_lsb(input int row, input int col);
        return WIN_W - PIX_W * (row * KERNEL + col + 1);
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// Line store for the four previous lines, one word per column.
// Single address port: the word at addr is read and overwritten in the same cycle.
module sobel_line_buf #(
    parameter int WIDTH = 640,
    parameter int PIX_W = 8,
    parameter int LINES = 4,
    parameter int AW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                   clock,
    input  logic                   we,
    input  logic [AW-1:0]          addr,
    input  logic [LINES*PIX_W-1:0] wdata,
    output logic [LINES*PIX_W-1:0] rdata
);

    logic [LINES*PIX_W-1:0] mem [WIDTH];

    assign rdata = mem[addr];

    // RAM write port
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Raster-to-window sequencer for the 5x5 Sobel datapath: line buffering,
// window assembly, position tracking and latency-aligned result tagging.
module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int XW     = 11,
    parameter int YW     = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pix_valid,
    input  logic             pix_sof,
    input  logic [PIX_W-1:0] pix_in,
    output logic [WIN_W-1:0] matrix_out,
    input  logic [PIX_W-1:0] edge_in,
    output logic             edge_valid,
    output logic [PIX_W-1:0] edge_out,
    output logic [XW-1:0]    edge_x,
    output logic [YW-1:0]    edge_y,
    output logic             busy,
    output logic             frame_done
);

    localparam int LB_AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [1:0]       drain_q, drain_d;
    logic [PIX_W-1:0] win_q [KERNEL][KERNEL];
    logic [PIX_W-1:0] win_d [KERNEL][KERNEL];
    logic             tag_vld_q  [TAG_DEPTH];
    logic             tag_vld_d  [TAG_DEPTH];
    logic             tag_last_q [TAG_DEPTH];
    logic             tag_last_d [TAG_DEPTH];
    logic [XW-1:0]    tag_x_q    [TAG_DEPTH];
    logic [XW-1:0]    tag_x_d    [TAG_DEPTH];
    logic [YW-1:0]    tag_y_q    [TAG_DEPTH];
    logic [YW-1:0]    tag_y_d    [TAG_DEPTH];
    logic             edge_valid_q, edge_valid_d;
    logic [PIX_W-1:0] edge_out_q, edge_out_d;
    logic [XW-1:0]    edge_x_q, edge_x_d;
    logic [YW-1:0]    edge_y_q, edge_y_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;

    logic             accept, restart, x_last, y_last, interior;
    logic [XW-1:0]    px;
    logic [YW-1:0]    py;
    logic [LB_W-1:0]  lb_rd, lb_wd;

    // Position of the pixel on the bus; a start-of-frame pixel is always (0,0).
    always_comb begin
        restart  = pix_valid & pix_sof;
        accept   = pix_valid & (pix_sof | (state_q == ST_RUN));
        px       = pix_sof ? {XW{1'b0}} : x_q;
        py       = pix_sof ? {YW{1'b0}} : y_q;
        x_last   = (px == XW'(WIDTH - 1));
        y_last   = (py == YW'(HEIGHT - 1));
        interior = (px >= XW'(KERNEL - 1)) && (py >= YW'(KERNEL - 1));
        lb_wd    = {lb_rd[LB_W-PIX_W-1:0], pix_in};
    end

    sobel_line_buf #(
        .WIDTH (WIDTH),
        .PIX_W (PIX_W),
        .LINES (LB_LINES),
        .AW    (LB_AW)
    ) u_line_buf (
        .clock (clock),
        .we    (accept),
        .addr  (LB_AW'(px)),
        .wdata (lb_wd),
        .rdata (lb_rd)
    );

    // Frame sequencing and raster counters
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (restart) state_d = ST_RUN;
                else         state_d = ST_IDLE;
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            ST_DRAIN: begin
                if (restart)                    state_d = ST_RUN;
                else if (drain_q == DRAIN_LAST) state_d = ST_IDLE;
                else                            drain_d = drain_q + 2'd1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (accept) begin
            x_d = x_last ? {XW{1'b0}} : px + XW'(1);
            y_d = x_last ? (y_last ? {YW{1'b0}} : py + YW'(1)) : py;
            if (x_last && y_last) begin
                state_d = ST_DRAIN;
                drain_d = 2'd0;
            end else begin
                drain_d = drain_d;
            end
        end else begin
            x_d = x_q;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // Window shift: oldest line on top, new column enters on the right.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
            end
            for (int r = 0; r < KERNEL - 1; r++) begin
                win_d[r][KERNEL-1] = lb_rd[LB_W-1-r*PIX_W -: PIX_W];
            end
            win_d[KERNEL-1][KERNEL-1] = pix_in;
        end else begin
            win_d = win_q;
        end
        matrix_out = {WIN_W{1'b0}};
        for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL; c++) begin
                matrix_out[win_lsb(r, c) +: PIX_W] = win_q[r][c];
            end
        end
    end

    // Result tags ride alongside the datapath; a new frame flushes them.
    always_comb begin
        tag_vld_d[0]  = accept & interior;
        tag_last_d[0] = x_last & y_last;
        tag_x_d[0]    = px - XW'(KERNEL / 2);
        tag_y_d[0]    = py - YW'(KERNEL / 2);
        for (int i = 1; i < TAG_DEPTH; i++) begin
            tag_vld_d[i]  = tag_vld_q[i-1] & ~restart;
            tag_last_d[i] = tag_last_q[i-1];
            tag_x_d[i]    = tag_x_q[i-1];
            tag_y_d[i]    = tag_y_q[i-1];
        end
        edge_valid_d = tag_vld_q[TAG_DEPTH-1] & ~restart;
        frame_done_d = edge_valid_d & tag_last_q[TAG_DEPTH-1];
        edge_out_d   = edge_in;
        edge_x_d     = tag_x_q[TAG_DEPTH-1];
        edge_y_d     = tag_y_q[TAG_DEPTH-1];
    end

    // State, window, tag and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            x_q          <= {XW{1'b0}};
            y_q          <= {YW{1'b0}};
            drain_q      <= 2'd0;
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL; c++) begin
                    win_q[r][c] <= {PIX_W{1'b0}};
                end
            end
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_vld_q[i]  <= 1'b0;
                tag_last_q[i] <= 1'b0;
                tag_x_q[i]    <= {XW{1'b0}};
                tag_y_q[i]    <= {YW{1'b0}};
            end
            edge_valid_q <= 1'b0;
            edge_out_q   <= {PIX_W{1'b0}};
            edge_x_q     <= {XW{1'b0}};
            edge_y_q     <= {YW{1'b0}};
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            drain_q      <= drain_d;
            win_q        <= win_d;
            tag_vld_q    <= tag_vld_d;
            tag_last_q   <= tag_last_d;
            tag_x_q      <= tag_x_d;
            tag_y_q      <= tag_y_d;
            edge_valid_q <= edge_valid_d;
            edge_out_q   <= edge_out_d;
            edge_x_q     <= edge_x_d;
            edge_y_q     <= edge_y_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign edge_valid = edge_valid_q;
    assign edge_out   = edge_out_q;
    assign edge_x     = edge_x_q;
    assign edge_y     = edge_y_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Randomized bench for sobel_window_ctrl: a behavioural Sobel stands in for the
// datapath, and expected results are computed directly from the frame image.
module tb_sobel_window_ctrl;
    import sobel_pkg::*;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int XW = 11;
    localparam int YW = 10;

    logic             clock = 1'b0;
    logic             reset;
    logic             pix_valid, pix_sof;
    logic [7:0]       pix_in;
    logic [WIN_W-1:0] matrix_out;
    logic [7:0]       edge_in, edge_out;
    logic             edge_valid, busy, frame_done;
    logic [XW-1:0]    edge_x;
    logic [YW-1:0]    edge_y;

    typedef struct {
        int due;
        int x;
        int y;
        int e;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   img[H][W];
    int   cyc = 0;
    int   res_cnt = 0;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] p1, p2, p3;

    sobel_window_ctrl #(.WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW)) dut (
        .clock(clock), .reset(reset), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_in(pix_in), .matrix_out(matrix_out), .edge_in(edge_in),
        .edge_valid(edge_valid), .edge_out(edge_out), .edge_x(edge_x),
        .edge_y(edge_y), .busy(busy), .frame_done(frame_done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // 5x5 Sobel magnitude |Gx|+|Gy|, mapped so strong edges go dark.
    function automatic logic [7:0] sobel_val(input int w[25]);
        int rw[5];
        int cw[5];
        int gx, gy, mag;
        rw = '{1, 4, 6, 4, 1};
        cw = '{-1, -2, 0, 2, 1};
        gx = 0;
        gy = 0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                gx += rw[r] * cw[c] * w[r*5+c];
                gy += cw[r] * rw[c] * w[r*5+c];
            end
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (mag >= 256) ? 8'h00 : 8'(255 - mag);
    endfunction

    function automatic logic [7:0] sobel_win(input logic [WIN_W-1:0] m);
        int w[25];
        for (int z = 0; z < 25; z++) w[z] = int'(m[WIN_W-1-8*z -: 8]);
        return sobel_val(w);
    endfunction

    function automatic logic [7:0] ref_edge(input int cx, input int cy);
        int w[25];
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) w[r*5+c] = img[cy-2+r][cx-2+c];
        return sobel_val(w);
    endfunction

    // Stand-in datapath with three register stages.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            p1 <= 8'h00; p2 <= 8'h00; p3 <= 8'h00;
        end else begin
            p1 <= sobel_win(matrix_out); p2 <= p1; p3 <= p2;
        end
    end
    assign edge_in = p3;

    // Result monitor against the expected queue.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                check_eq("result_missing_due", cyc, exp_q[0].due);
                exp_q.delete(0);
            end
            if (edge_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_edge_valid", edge_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    res_cnt++;
                    check_eq("edge_latency", cyc, e.due);
                    check_eq("edge_x", edge_x, e.x);
                    check_eq("edge_y", edge_y, e.y);
                    check_eq("edge_out", edge_out, e.e);
                    check_eq("frame_done", frame_done, e.last);
                end
            end else if (frame_done) begin
                check_eq("frame_done_without_valid", frame_done, 0);
            end
        end
    end

    task automatic set_img(input int mode);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                case (mode)
                    0:       img[y][x] = 100;
                    1:       img[y][x] = (x >= 4) ? 60 : 0;
                    default: img[y][x] = $urandom_range(3);
                endcase
    endtask

    task automatic send_frame(input int npix, input int gap_pct, output int last_acc);
        int acc;
        exp_t e;
        acc = cyc;
        for (int idx = 0; idx < npix; idx++) begin
            while ($urandom_range(99) < gap_pct) begin
                pix_valid = 1'b0;
                pix_sof   = 1'($urandom_range(1));
                pix_in    = 8'($urandom_range(255));
                @(posedge clock); #1;
            end
            pix_valid = 1'b1;
            pix_sof   = (idx == 0);
            pix_in    = 8'(img[idx/W][idx%W]);
            @(posedge clock); #1;
            acc = cyc;
            if (idx == 0) begin
                while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due >= acc)
                    exp_q.delete(exp_q.size()-1);
                res_cnt = 0;
            end
            if (idx % W >= 4 && idx / W >= 4) begin
                e.due  = acc + 4;
                e.x    = idx % W - 2;
                e.y    = idx / W - 2;
                e.e    = ref_edge(e.x, e.y);
                e.last = (idx == W*H - 1);
                exp_q.push_back(e);
            end
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        last_acc  = acc;
    endtask

    task automatic finish_frame(input string tag);
        repeat (3) @(posedge clock);
        #1 check_eq({tag, "_busy_l3"}, busy, 1);
        @(posedge clock); #1;
        check_eq({tag, "_busy_l4"}, busy, 0);
        @(negedge clock); #1;
        check_eq({tag, "_result_count"}, res_cnt, (W-4)*(H-4));
        check_eq({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_edge_valid"}, edge_valid, 0);
        check_eq({tag, "_edge_out"}, edge_out, 0);
        check_eq({tag, "_edge_x"}, edge_x, 0);
        check_eq({tag, "_edge_y"}, edge_y, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_frame_done"}, frame_done, 0);
        check_eq({tag, "_matrix"}, |matrix_out, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int l;
        reset = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_in = 8'h00;
        repeat (3) @(posedge clock);
        #1 check_zero("reset");
        reset = 1'b0;
        @(posedge clock); #1;

        set_img(0); send_frame(W*H, 0, l);  finish_frame("flat");
        set_img(1); send_frame(W*H, 0, l);  finish_frame("step");
        set_img(1); send_frame(W*H, 50, l); finish_frame("step_gaps");
        for (int k = 0; k < 3; k++) begin
            set_img(2); send_frame(W*H, 30, l); finish_frame("random_gaps");
        end

        set_img(2); send_frame(4*W+3, 0, l);
        set_img(0); send_frame(W*H, 0, l); finish_frame("abort_3_4");
        set_img(2); send_frame(5*W+6, 0, l);
        set_img(2); send_frame(W*H, 0, l); finish_frame("abort_late");

        set_img(2); send_frame(20, 0, l);
        reset = 1'b1;
        #1 check_zero("mid_reset");
        exp_q.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            pix_valid = 1'b1; pix_sof = 1'b0; pix_in = 8'($urandom_range(255));
            @(posedge clock); #1;
            check_eq("stray_busy", busy, 0);
            check_eq("stray_matrix", |matrix_out, 0);
        end
        pix_valid = 1'b0;
        set_img(0); send_frame(W*H, 0, l); finish_frame("after_reset");

        repeat (4) @(posedge clock);
        #1 check_eq("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
